// File: rtl/word_scrambler.sv
// Purpose: latch a six-glyph word and shuffle glyph positions with LFSR-driven swaps.
// Latency: done rises NUM_SWAPS+1 edges after the edge that accepts start (one more if FIX is needed).
// Backpressure: none; start and Word changes are ignored while busy, Scram held until the next done.
module word_scrambler #(
  parameter int unsigned NUM_SWAPS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  DASH      = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] Word0,
  input  logic [7:0] Word1,
  input  logic [7:0] Word2,
  input  logic [7:0] Word3,
  input  logic [7:0] Word4,
  input  logic [7:0] Word5,
  output logic [7:0] Scram0,
  output logic [7:0] Scram1,
  output logic [7:0] Scram2,
  output logic [7:0] Scram3,
  output logic [7:0] Scram4,
  output logic [7:0] Scram5,
  output logic       busy,
  output logic       done
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  LAST_SWAP = 8'(NUM_SWAPS - 1);

  typedef enum logic [2:0] {IDLE, SWAP, CHECK, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [5:0][7:0]  work_q, work_d;
  logic [5:0][7:0]  orig_q, orig_d;
  logic [5:0][7:0]  scram_q, scram_d;
  logic [5:0][7:0]  word_in;
  logic [5:0][7:0]  rot;
  logic [2:0]       idx_i, idx_j;

  // Fold a 3-bit value into a glyph position 0..5.
  function automatic logic [2:0] fold_idx(input logic [2:0] v);
    return (v >= 3'd6) ? (v - 3'd6) : v;
  endfunction

  assign word_in = {Word5, Word4, Word3, Word2, Word1, Word0};
  assign idx_i   = fold_idx(lfsr_q[2:0]);
  assign idx_j   = fold_idx(lfsr_q[5:3]);

  // Galois LFSR free-runs in every state so results depend on start timing.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Left rotation used when the shuffle happened to restore the original order.
  always_comb begin
    rot = '0;
    for (int k = 0; k < 5; k++) rot[k] = work_q[k+1];
    rot[5] = work_q[0];
  end

  // Next-state logic: latch, swap, check for identity, optionally rotate, publish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    orig_d  = orig_q;
    scram_d = scram_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = word_in;
          orig_d  = word_in;
          cnt_d   = 8'd0;
          state_d = SWAP;
        end
      end
      SWAP: begin
        work_d[idx_i] = work_q[idx_j];
        work_d[idx_j] = work_q[idx_i];
        cnt_d         = cnt_q + 8'd1;
        if (cnt_q == LAST_SWAP) state_d = CHECK;
      end
      CHECK: begin
        if (work_q != orig_q) begin
          scram_d = work_q;
          state_d = DONE;
        end else begin
          state_d = FIX;
        end
      end
      FIX: begin
        work_d  = rot;
        scram_d = rot;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      cnt_q   <= 8'd0;
      work_q  <= '0;
      orig_q  <= '0;
      scram_q <= {6{DASH}};
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      orig_q  <= orig_d;
      scram_q <= scram_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign Scram0 = scram_q[0];
  assign Scram1 = scram_q[1];
  assign Scram2 = scram_q[2];
  assign Scram3 = scram_q[3];
  assign Scram4 = scram_q[4];
  assign Scram5 = scram_q[5];

endmodule

// File: tb/tb_word_scrambler.sv
// Directed bench for word_scrambler: table of words plus hand-written corner sequences.
// Expected results come from a reference LFSR/swap model stepped alongside the clock.
// All edges counted from the edge at which start is driven (edge 0); start is sampled at edge 1.
module tb_word_scrambler;

  typedef logic [5:0][7:0] w6_t;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          NSW  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] Word0 = 8'h00, Word1 = 8'h00, Word2 = 8'h00;
  logic [7:0] Word3 = 8'h00, Word4 = 8'h00, Word5 = 8'h00;
  logic [7:0] Scram0, Scram1, Scram2, Scram3, Scram4, Scram5;
  logic       busy, done;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_lfsr = SEED;

  word_scrambler #(.NUM_SWAPS(NSW), .LFSR_SEED(SEED), .DASH(8'h3F)) dut (
    .clk(clk), .rst(rst), .start(start),
    .Word0(Word0), .Word1(Word1), .Word2(Word2), .Word3(Word3), .Word4(Word4), .Word5(Word5),
    .Scram0(Scram0), .Scram1(Scram1), .Scram2(Scram2), .Scram3(Scram3), .Scram4(Scram4), .Scram5(Scram5),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  function automatic w6_t mk(input logic [7:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic w6_t scram_now();
    return {Scram5, Scram4, Scram3, Scram2, Scram1, Scram0};
  endfunction

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int pos(input logic [2:0] v);
    return (int'(v) >= 6) ? int'(v) - 6 : int'(v);
  endfunction

  // Reference: l0 is the LFSR value seen at the accepting edge.
  function automatic void model(input w6_t w, input logic [15:0] l0, output w6_t res, output bit fix);
    w6_t        wk;
    logic [15:0] l;
    logic [7:0] t;
    int         a, b;
    wk = w;
    l  = step(l0);
    for (int i = 0; i < NSW; i++) begin
      a = pos(l[2:0]);
      b = pos(l[5:3]);
      t = wk[a]; wk[a] = wk[b]; wk[b] = t;
      l = step(l);
    end
    if (wk != w) begin
      res = wk; fix = 1'b0;
    end else begin
      for (int k = 0; k < 5; k++) res[k] = wk[k+1];
      res[5] = wk[0];
      fix = 1'b1;
    end
  endfunction

  function automatic w6_t sorted(input w6_t w);
    w6_t        s;
    logic [7:0] t;
    s = w;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 5 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s;
  endfunction

  function automatic bit all_distinct(input w6_t w);
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++)
        if (w[i] == w[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) m_lfsr = step(m_lfsr);
  endtask

  task automatic set_words(input w6_t w);
    Word0 = w[0]; Word1 = w[1]; Word2 = w[2];
    Word3 = w[3]; Word4 = w[4]; Word5 = w[5];
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    start = 1'b0;
    m_lfsr = SEED;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  // One scramble from start to the idle cycle after done.
  task automatic run(input string tag, input w6_t w, input bit hold, input bit corrupt,
                     input bit fix_known, output w6_t got);
    w6_t exp_res, prev;
    bit  fix;
    int  done_at;
    bit  stable;
    prev    = scram_now();
    model(w, m_lfsr, exp_res, fix);
    set_words(w);
    start   = 1'b1;
    done_at = -1;
    stable  = 1'b1;
    for (int e = 1; e <= 40 && done_at < 0; e++) begin
      tick();
      if (e == 1) begin
        if (!hold) start = 1'b0;
        chk({tag, "_busy_e1"}, 64'(busy), 64'd1);
      end
      if (corrupt && e == 5) begin
        start = 1'b1;
        set_words(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
      end
      if (corrupt && e == 6) start = 1'b0;
      if (done) done_at = e;
      else if (scram_now() !== prev) stable = 1'b0;
    end
    chk({tag, "_done_edge"}, 64'(done_at), fix ? 64'(NSW + 3) : 64'(NSW + 2));
    if (fix_known) chk({tag, "_fix_edge"}, 64'(done_at), 64'(NSW + 3));
    chk({tag, "_stable"}, 64'(stable), 64'd1);
    chk({tag, "_scram"}, 64'(scram_now()), 64'(exp_res));
    chk({tag, "_perm"}, 64'(sorted(scram_now())), 64'(sorted(w)));
    if (all_distinct(w)) chk({tag, "_differs"}, 64'(scram_now() != w), 64'd1);
    got = scram_now();
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    w6_t w;
    int  gap;
    bit  fix_known;
  } vec_t;

  initial begin
    vec_t tbl[5];
    w6_t  dw, r1, r2, g;
    int   ndone;

    dw = mk(8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71);
    tbl[0] = '{dw, 0, 1'b0};
    tbl[1] = '{mk(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F), 2, 1'b1};
    tbl[2] = '{mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06), 7, 1'b0};
    tbl[3] = '{mk(8'h06, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D), 1, 1'b0};
    tbl[4] = '{dw, 3, 1'b0};

    // Reset held for three cycles, then idle.
    do_reset(3);
    chk("rst_scram", 64'(scram_now()), 64'({6{8'h3F}}));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy || scram_now() !== {6{8'h3F}}) ndone++;
    end
    chk("idle_quiet", 64'(ndone), 64'd0);

    // Table of words with varied idle gaps before start.
    for (int i = 0; i < 5; i++) begin
      repeat (tbl[i].gap) tick();
      run($sformatf("vec%0d", i), tbl[i].w, 1'b0, 1'b0, tbl[i].fix_known, g);
    end

    // Determinism: identical reset-to-start timing gives identical output.
    do_reset(3);
    repeat (5) tick();
    run("det1", dw, 1'b0, 1'b0, 1'b0, r1);
    do_reset(3);
    repeat (5) tick();
    run("det2", dw, 1'b0, 1'b0, 1'b0, r2);
    chk("det_repeat", 64'(r2), 64'(r1));

    // Start held high: re-accepted in the first idle cycle after done.
    run("hold1", dw, 1'b1, 1'b0, 1'b0, g);
    run("hold2", tbl[2].w, 1'b0, 1'b0, 1'b0, g);

    // Start re-pulsed and Word zeroed mid-swap: latched copy wins.
    tick();
    run("corrupt", dw, 1'b0, 1'b1, 1'b0, g);

    // Reset asserted at swap cycle 8.
    set_words(dw);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    m_lfsr = SEED;
    #1;
    chk("midrst_scram", 64'(scram_now()), 64'({6{8'h3F}}));
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    chk("midrst_scram_held", 64'(scram_now()), 64'({6{8'h3F}}));
    run("after_rst", dw, 1'b0, 1'b0, 1'b0, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
